// File: rtl/ppu_pkg.sv
// ppu_pkg: shared ppu mode/scheduler types and timing constants.
package ppu_pkg;
  localparam int PPU_LINE = 799;
  localparam int PPU_SCREEN = 524;
  localparam logic [7:0] CFG_CLEAR = 8'hE0;
  typedef enum logic [2:0] {
    MODE_PASS, MODE_1, MODE_2, MODE_3, MODE_4, MODE_5, MODE_6, MODE_7
  } ppu_mode_e;
  typedef enum logic [1:0] {IDLE, ARMED, RUN, HOLD} sched_state_e;
endpackage

// File: rtl/ppu_frame_timer.sv
// ppu_frame_timer: sx/sy raster counters and a strobe one cycle before the last pixel of a frame.
module ppu_frame_timer
  import ppu_pkg::*;
#(
  parameter int LINE = PPU_LINE,
  parameter int SCREEN = PPU_SCREEN
) (
  input  logic clk,
  input  logic rst,
  output logic pre_edge
);
  localparam int XW = $clog2(LINE + 1);
  localparam int YW = $clog2(SCREEN + 1);
  logic [XW-1:0] sx;
  logic [YW-1:0] sy;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sx <= '0;
      sy <= '0;
    end else if (sx == XW'(LINE)) begin
      sx <= '0;
      sy <= (sy == YW'(SCREEN)) ? '0 : sy + 1'b1;
    end else begin
      sx <= sx + 1'b1;
    end
  end
  assign pre_edge = (sx == XW'(LINE - 1)) && (sy == YW'(SCREEN));
endmodule

// File: rtl/ppu_mode_sched.sv
// ppu_mode_sched: frame-synchronous playlist scheduler driving ppu mode/sync.
// Define PPU_SCHED_LOOP_EN to loop the playlist; otherwise the last slot is held.
module ppu_mode_sched
  import ppu_pkg::*;
#(
  parameter int SLOTS = 8,
  parameter int SLOT_BITS = 3,
  parameter logic [2:0] DEFAULT_MODE = 3'd0,
  parameter int LINE = PPU_LINE,
  parameter int SCREEN = PPU_SCREEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [7:0]           cfg_data,
  input  logic                 cfg_stb,
  output logic                 cfg_ack,
  output logic [2:0]           mode,
  output logic                 sync,
  output logic [SLOT_BITS-1:0] slot_idx,
  output logic                 running,
  output logic                 overflow
);
`ifdef PPU_SCHED_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  localparam ppu_mode_e DEF = ppu_mode_e'(DEFAULT_MODE);

  logic [7:0]           slot_tab [SLOTS];
  logic [SLOT_BITS:0]   len, nxt;
  logic [SLOT_BITS-1:0] load_idx, idx_nxt;
  logic [4:0]           dwell, dwell_nxt;
  logic                 pre_edge, clear_hit, wr, room, stop, wrap, sync_nxt, clr_pend;
  sched_state_e         state, state_nxt;
  ppu_mode_e            mode_q, mode_nxt;

  ppu_frame_timer #(.LINE(LINE), .SCREEN(SCREEN)) u_timer (
    .clk(clk), .rst(rst), .pre_edge(pre_edge)
  );

  assign clear_hit = cfg_stb && (cfg_data == CFG_CLEAR);
  assign wr        = cfg_stb && (cfg_data[4:0] != 5'd0);
  assign room      = len < (SLOT_BITS + 1)'(SLOTS);
  assign stop      = !enable || clr_pend;
  assign nxt       = {1'b0, slot_idx} + 1'b1;
  assign wrap      = nxt >= len;
  assign load_idx  = wrap ? '0 : nxt[SLOT_BITS-1:0];
  assign mode      = mode_q;
  assign running   = (state == RUN) || (state == HOLD);

  // Table write lands after any same-cycle pre_edge read, so the switch sees the old entry
  always_ff @(posedge clk) begin
    if (wr && room) slot_tab[len[SLOT_BITS-1:0]] <= cfg_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_ack  <= 1'b0;
      len      <= '0;
      overflow <= 1'b0;
    end else begin
      cfg_ack <= cfg_stb;
      if (clear_hit) begin
        len      <= '0;
        overflow <= 1'b0;
      end else if (wr) begin
        if (room) len <= len + 1'b1;
        else overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    idx_nxt   = slot_idx;
    dwell_nxt = dwell;
    sync_nxt  = 1'b0;
    case (state)
      IDLE: begin
        mode_nxt = DEF;
        if (enable && len != '0) state_nxt = ARMED;
      end
      ARMED: begin
        if (stop) state_nxt = IDLE;
        else if (pre_edge) begin
          idx_nxt   = '0;
          mode_nxt  = ppu_mode_e'(slot_tab[0][7:5]);
          dwell_nxt = slot_tab[0][4:0];
          sync_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN, HOLD: begin
        if (pre_edge) begin
          if (stop) begin
            mode_nxt  = DEF;
            sync_nxt  = 1'b1;
            state_nxt = IDLE;
          end else if (state == RUN) begin
            if (dwell > 5'd1) dwell_nxt = dwell - 5'd1;
            else if (wrap && !LOOP) state_nxt = HOLD;
            else begin
              idx_nxt   = load_idx;
              mode_nxt  = ppu_mode_e'(slot_tab[load_idx][7:5]);
              dwell_nxt = slot_tab[load_idx][4:0];
              sync_nxt  = 1'b1;
            end
          end
        end
      end
    endcase
  end

  // A CLEAR outside IDLE is remembered until the stop actually happens
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mode_q   <= DEF;
      slot_idx <= '0;
      dwell    <= '0;
      sync     <= 1'b0;
      clr_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      mode_q   <= mode_nxt;
      slot_idx <= idx_nxt;
      dwell    <= dwell_nxt;
      sync     <= sync_nxt;
      clr_pend <= (state_nxt != IDLE) && (clr_pend || clear_hit);
    end
  end
endmodule

// File: tb/tb_ppu_mode_sched.sv
// tb_ppu_mode_sched: scoreboard bench; expected sync events are queued and checked as they occur.
module tb_ppu_mode_sched;
  logic       clk, rst, enable, cfg_stb, cfg_ack, sync, running, overflow;
  logic [7:0] cfg_data;
  logic [2:0] mode, slot_idx;

  typedef struct {
    logic [2:0] mode;
    logic [2:0] slot;
    logic       cs;
    logic       run;
    int         gap;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_m;
  int n_cmp = 0, n_err = 0;
  int gap;
  logic sync_d;
  logic [2:0] mode_d;

  ppu_mode_sched #(.LINE(9), .SCREEN(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_data(cfg_data), .cfg_stb(cfg_stb),
    .cfg_ack(cfg_ack), .mode(mode), .sync(sync), .slot_idx(slot_idx),
    .running(running), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int m, input int s, input bit cs, input bit run, input int g);
    exp_t e;
    e.mode = 3'(m);
    e.slot = 3'(s);
    e.cs   = cs;
    e.run  = run;
    e.gap  = g;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    cfg_data = b;
    cfg_stb  = 1'b1;
    @(negedge clk);
    cfg_stb = 1'b0;
    check("ack", cfg_ack, 1);
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic wait_sync(input int max);
    for (int i = 0; i < max && !sync; i++) @(negedge clk);
    check("sync_seen", sync, 1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      gap    = 0;
      sync_d = 1'b0;
      mode_d = mode;
    end else begin
      gap++;
      if (!sync) check("mode_hold", mode, mode_d);
      else begin
        check("sync_b2b", sync_d, 0);
        if (exp_q.size() == 0) check("sync_unexp", sync, 0);
        else begin
          e_m = exp_q.pop_front();
          check("sync_mode", mode, e_m.mode);
          check("sync_running", running, e_m.run);
          if (e_m.cs) check("sync_slot", slot_idx, e_m.slot);
          if (e_m.gap != 0) check("sync_gap", gap, e_m.gap);
        end
        gap = 0;
      end
      sync_d = sync;
      mode_d = mode;
    end
  end

  initial begin
    int c;
    rst = 1'b0; enable = 1'b0; cfg_data = '0; cfg_stb = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mode", mode, 0);
    check("rst_sync", sync, 0);
    check("rst_ack", cfg_ack, 0);
    check("rst_slot", slot_idx, 0);
    check("rst_running", running, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk) rst = 1'b1;

    send(8'h20);
    send(8'h00);
    @(negedge clk);
    check("ack_low", cfg_ack, 0);
    enable = 1'b1;
    repeat (120) @(negedge clk);
    check("dwell0_running", running, 0);
    check("dwell0_mode", mode, 0);
    enable = 1'b0;

    send(8'h42);
    send(8'h61);
    push(2, 0, 1, 1, 0);
    push(3, 1, 1, 1, 100);
`ifdef PPU_SCHED_LOOP_EN
    push(2, 0, 1, 1, 50);
    push(3, 1, 1, 1, 100);
`endif
    enable = 1'b1;
    drain(400);
`ifndef PPU_SCHED_LOOP_EN
    repeat (150) @(negedge clk);
    check("hold_mode", mode, 3);
    check("hold_slot", slot_idx, 1);
    check("hold_running", running, 1);
`endif
    repeat (10) @(negedge clk);
    enable = 1'b0;
`ifdef PPU_SCHED_LOOP_EN
    push(0, 0, 0, 0, 50);
`else
    push(0, 0, 0, 0, 0);
`endif
    @(negedge clk);
    check("stop_pending_running", running, 1);
    check("stop_pending_mode", mode, 3);
    drain(100);
    check("stop_running", running, 0);
    check("stop_mode", mode, 0);

    send(8'hE0);
    for (int i = 0; i < 8; i++) send({i[2:0], 5'd1});
    check("ovf_full", overflow, 0);
    send(8'hA3);
    check("ovf_set", overflow, 1);
    send(8'hE0);
    check("ovf_clear", overflow, 0);

    send(8'h21);
    push(1, 0, 1, 1, 0);
`ifdef PPU_SCHED_LOOP_EN
    push(1, 0, 1, 1, 50);
    push(4, 1, 1, 1, 50);
    push(1, 0, 1, 1, 100);
`endif
    enable = 1'b1;
    wait_sync(200);
    repeat (49) @(negedge clk);
    cfg_data = 8'h82;
    cfg_stb  = 1'b1;
    @(negedge clk);
    cfg_stb = 1'b0;
`ifdef PPU_SCHED_LOOP_EN
    drain(400);
`else
    repeat (120) @(negedge clk);
    check("race_mode", mode, 1);
    check("race_slot", slot_idx, 0);
    check("race_running", running, 1);
`endif

    send(8'hE0);
    push(0, 0, 0, 0, 0);
    drain(200);
    check("clear_running", running, 0);
    check("clear_mode", mode, 0);
    enable = 1'b0;

    push(2, 0, 1, 1, 0);
    push(3, 1, 1, 1, 50);
    send(8'h41);
    send(8'h61);
    enable = 1'b1;
    drain(200);
    repeat (20) @(negedge clk);
    send(8'h00);
    #2 rst = 1'b0;
    #1;
    check("arst_mode", mode, 0);
    check("arst_sync", sync, 0);
    check("arst_running", running, 0);
    check("arst_slot", slot_idx, 0);
    check("arst_ack", cfg_ack, 0);
    check("arst_overflow", overflow, 0);
    cfg_data = 8'h41;
    cfg_stb  = 1'b1;
    push(2, 0, 1, 1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cfg_stb = 1'b0;
    c = 1;
    while (!sync && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("arst_phase", c, 49);
    enable = 1'b0;
    push(0, 0, 0, 0, 50);
    drain(200);
    check("final_running", running, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
